mempool_lrwait_table: RTL and testbench
=======================================

Name: mempool_lrwait_table

Overview:
- Per-bank reservation unit for LR/SC and LRWait atomics, placed in front of each TCDM bank's request port.
- Tracks up to NumLrWaitAddr reserved word addresses, each with one owner and a FIFO of deferred LRWait requesters.
- Decides SC success and suppresses writes of failed SCs.
- When a reservation is released, hands it to the next waiter, emitting a wake token so the waiter's LR is replayed into the bank.

Parameters:
- NumLrWaitAddr, 4, number of reservation entries.
- QueueDepth, 4, deferred waiters per entry (power of two, >=2).
- AddrWidth, 8, bank word address width (TCDMAddrMemWidth).
- IdWidth, 8, initiator identifier width (core id + meta id).
- CntWidth, 16, statistics counter width (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_addr_i  in  AddrWidth  word address.
- req_amo_i  in  4  amo_t opcode.
- req_lrwait_i  in  1  LR is an LRWait.
- req_wen_i  in  1  write request.
- req_id_i  in  IdWidth  initiator id.
- dec_valid_o  out  1  decision for the request accepted last cycle.
- dec_wen_o  out  1  write enable forwarded to bank (0 for a failed SC).
- dec_sc_ok_o  out  1  SC succeeded.
- dec_defer_o  out  1  LRWait queued; bank must not respond now.
- wake_valid_o  out  1  promoted waiter pending replay.
- wake_ready_i  in  1  bank has accepted the replay.
- wake_id_o  out  IdWidth  promoted waiter id.
- wake_addr_o  out  AddrWidth  reserved address.

Behaviour:
- Reset: all entries invalid, queues empty, wake_valid_o=0, dec_* = 0, counters 0. The table is cleared immediately on reset, mid-operation included; deferred requesters are dropped.
- Opcode classes: AMO_LR=4'hA, AMO_SC=4'hB; any other request with req_wen_i=1 is a plain write.
- Lookup: combinational address match over valid entries (addresses unique by construction). State updates on the accepting edge, so back-to-back requests see updated state.
- Decision is registered: dec_valid_o is 1 exactly one cycle after acceptance. There is no backpressure on dec.
- req_ready_o = !wake_valid_o || wake_ready_i.
- LR, no match, free entry available: allocate lowest free index with owner=id.
  - dec_defer_o=0.
- LR with a match:
  - Non-LRWait, or LRWait with a full queue: no reservation change, dec_defer_o=0. Overwrite is not allowed; the later SC fails.
  - LRWait with queue space: push id, dec_defer_o=1.
- LR with table full: dec_defer_o=0, no reservation is taken.
- SC: success iff a match exists and owner==id.
  - Success: dec_sc_ok_o=1, dec_wen_o=1, reservation released.
  - Failure: dec_sc_ok_o=0, dec_wen_o=0, table unchanged.
- Plain write to a matched address: dec_wen_o=1 and the reservation is released, regardless of writer.
- Release:
  - Queue empty: entry invalidated.
  - Queue non-empty: pop head, owner=head, load wake register {id, addr}, wake_valid_o=1 until wake_ready_i.
- Wake register is single-entry; a release and a wake handshake in the same cycle are allowed because ready covers it.
- Reads and other AMOs pass through with dec_wen_o=req_wen_i and no table effect.
- Queue pointers use log2(QueueDepth) bits plus a wrap bit; full when the pointers are equal and the wrap bits differ.

Optional Feature:
- Macro MEMPOOL_LRWAIT_STATS_EN.
- Defined: adds outputs stat_defer_o, stat_sc_fail_o, stat_table_full_o (CntWidth each).
  - Each counts the corresponding accepted event.
  - Counters saturate at all-ones and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- mempool_pkg gains AMO_LR and AMO_SC constants, LrWaitQueueDepth, and typedef lrwait_entry_t {valid, addr, owner}.
- Sub-module mempool_lrwait_queue: parametrised circular FIFO (push, pop, head, full, empty), one instance per entry.

Test Plan:
- LR(id 3, addr 0x10), then SC(id 3, 0x10) -> SC dec_sc_ok_o=1, dec_wen_o=1; entry freed.
- LR(id 3, 0x10), then store(id 5, 0x10), then SC(id 3) -> SC fails, dec_wen_o=0.
- LRWait id 1, 2, 3 to 0x20 -> defer 0, 1, 1. SC(id 1) -> wake_id_o=2, wake_addr_o=0x20. Then SC(id 2) -> wake_id_o=3.
- Fill 4 entries (0x00–0x03); LR id 9 to 0x04 -> defer 0; SC(id 9, 0x04) fails.
- Hold wake_ready_i=0 with wake pending -> req_ready_o=0. Raise wake_ready_i -> same-cycle request accepted.
- Assert rst_i with 2 queued waiters -> next cycle all entries invalid, wake_valid_o=0; a fresh LR allocates entry 0.

Source files
------------

// File: rtl/mempool_lrwait_table_pkg.sv
// Shared constants and types for the per-bank LR/SC + LRWait reservation table.
package mempool_lrwait_table_pkg;

  localparam logic [3:0] AMO_NONE = 4'h0;
  localparam logic [3:0] AMO_LR   = 4'hA;
  localparam logic [3:0] AMO_SC   = 4'hB;

  localparam int unsigned LrWaitQueueDepth = 4;
  localparam int unsigned LrWaitAddrWidth  = 8;
  localparam int unsigned LrWaitIdWidth    = 8;

  typedef struct packed {
    logic                       valid;
    logic [LrWaitAddrWidth-1:0] addr;
    logic [LrWaitIdWidth-1:0]   owner;
  } lrwait_entry_t;

  // Anything that is neither LR nor SC but writes the bank breaks a reservation.
  function automatic logic is_plain_write(input logic [3:0] amo, input logic wen);
    return wen && (amo != AMO_LR) && (amo != AMO_SC);
  endfunction

endpackage

// File: rtl/mempool_lrwait_queue.sv
// Circular FIFO of deferred LRWait requester ids; wrap-bit pointers tell full from empty.
module mempool_lrwait_queue #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);

  logic [PtrWidth:0]    wr_ptr_q, rd_ptr_q;
  logic [DataWidth-1:0] mem_q [Depth];
  logic                 do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrWidth] != rd_ptr_q[PtrWidth]) &&
                   (wr_ptr_q[PtrWidth-1:0] == rd_ptr_q[PtrWidth-1:0]);
  assign data_o  = mem_q[rd_ptr_q[PtrWidth-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PtrWidth-1:0]] <= data_i;
  end

endmodule

// File: rtl/mempool_lrwait_table.sv
// Per-bank LR/SC + LRWait reservation table with deferred-waiter hand-off and wake token.
// Optional saturating event counters when MEMPOOL_LRWAIT_STATS_EN is defined.
module mempool_lrwait_table
  import mempool_lrwait_table_pkg::*;
#(
  parameter int unsigned NumLrWaitAddr = 4,
  parameter int unsigned QueueDepth    = LrWaitQueueDepth,
  parameter int unsigned AddrWidth     = 8,
  parameter int unsigned IdWidth       = 8,
  parameter int unsigned CntWidth      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [3:0]           req_amo_i,
  input  logic                 req_lrwait_i,
  input  logic                 req_wen_i,
  input  logic [IdWidth-1:0]   req_id_i,
  output logic                 dec_valid_o,
  output logic                 dec_wen_o,
  output logic                 dec_sc_ok_o,
  output logic                 dec_defer_o,
  output logic                 wake_valid_o,
  input  logic                 wake_ready_i,
  output logic [IdWidth-1:0]   wake_id_o,
  output logic [AddrWidth-1:0] wake_addr_o
`ifdef MEMPOOL_LRWAIT_STATS_EN
  ,
  output logic [CntWidth-1:0]  stat_defer_o,
  output logic [CntWidth-1:0]  stat_sc_fail_o,
  output logic [CntWidth-1:0]  stat_table_full_o
`endif
);

  localparam int unsigned IdxWidth = (NumLrWaitAddr > 1) ? $clog2(NumLrWaitAddr) : 1;

  typedef struct packed {
    logic                 valid;
    logic [AddrWidth-1:0] addr;
    logic [IdWidth-1:0]   owner;
  } entry_t;

  entry_t [NumLrWaitAddr-1:0] tbl_q, tbl_d;

  logic [NumLrWaitAddr-1:0] q_push, q_pop, q_full, q_empty;
  logic [IdWidth-1:0]       q_head [NumLrWaitAddr];

  logic                 accept, is_lr, is_sc, is_wr;
  logic                 hit, has_free;
  logic [IdxWidth-1:0]  hit_idx, free_idx;
  logic                 alloc, release_res, table_full;
  logic                 dec_wen_d, dec_sc_ok_d, dec_defer_d, sc_fail;
  logic                 wake_load;

  logic                 dec_valid_q, dec_wen_q, dec_sc_ok_q, dec_defer_q;
  logic                 wake_valid_q;
  logic [IdWidth-1:0]   wake_id_q;
  logic [AddrWidth-1:0] wake_addr_q;

  assign req_ready_o = !wake_valid_q || wake_ready_i;
  assign accept      = req_valid_i && req_ready_o;
  assign is_lr       = (req_amo_i == AMO_LR);
  assign is_sc       = (req_amo_i == AMO_SC);
  assign is_wr       = is_plain_write(req_amo_i, req_wen_i);

  // Descending scan so the lowest free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = NumLrWaitAddr - 1; i >= 0; i--) begin
      if (tbl_q[i].valid && (tbl_q[i].addr == req_addr_i)) begin
        hit     = 1'b1;
        hit_idx = IdxWidth'(i);
      end
      if (!tbl_q[i].valid) begin
        has_free = 1'b1;
        free_idx = IdxWidth'(i);
      end
    end
  end

  always_comb begin
    dec_wen_d   = req_wen_i;
    dec_sc_ok_d = 1'b0;
    dec_defer_d = 1'b0;
    alloc       = 1'b0;
    release_res = 1'b0;
    table_full  = 1'b0;
    sc_fail     = 1'b0;
    if (is_lr) begin
      if (hit) begin
        dec_defer_d = req_lrwait_i && !q_full[hit_idx];
      end else if (has_free) begin
        alloc = 1'b1;
      end else begin
        table_full = 1'b1;
      end
    end else if (is_sc) begin
      dec_sc_ok_d = hit && (tbl_q[hit_idx].owner == req_id_i);
      dec_wen_d   = dec_sc_ok_d;
      release_res = dec_sc_ok_d;
      sc_fail     = !dec_sc_ok_d;
    end else if (is_wr) begin
      release_res = hit;
    end
  end

  // On release the head waiter inherits ownership and is woken to replay its LR.
  always_comb begin
    tbl_d     = tbl_q;
    q_push    = '0;
    q_pop     = '0;
    wake_load = 1'b0;
    if (accept) begin
      if (alloc) begin
        tbl_d[free_idx] = '{valid: 1'b1, addr: req_addr_i, owner: req_id_i};
      end
      if (dec_defer_d) q_push[hit_idx] = 1'b1;
      if (release_res) begin
        if (q_empty[hit_idx]) begin
          tbl_d[hit_idx].valid = 1'b0;
        end else begin
          q_pop[hit_idx]       = 1'b1;
          tbl_d[hit_idx].owner = q_head[hit_idx];
          wake_load            = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NumLrWaitAddr; g++) begin : gen_queue
    mempool_lrwait_queue #(
      .Depth     (QueueDepth),
      .DataWidth (IdWidth)
    ) u_queue (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (q_push[g]),
      .data_i  (req_id_i),
      .pop_i   (q_pop[g]),
      .data_o  (q_head[g]),
      .full_o  (q_full[g]),
      .empty_o (q_empty[g])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tbl_q        <= '0;
      dec_valid_q  <= 1'b0;
      dec_wen_q    <= 1'b0;
      dec_sc_ok_q  <= 1'b0;
      dec_defer_q  <= 1'b0;
      wake_valid_q <= 1'b0;
      wake_id_q    <= '0;
      wake_addr_q  <= '0;
    end else begin
      tbl_q       <= tbl_d;
      dec_valid_q <= accept;
      dec_wen_q   <= accept && dec_wen_d;
      dec_sc_ok_q <= accept && dec_sc_ok_d;
      dec_defer_q <= accept && dec_defer_d;
      if (wake_load) begin
        wake_valid_q <= 1'b1;
        wake_id_q    <= q_head[hit_idx];
        wake_addr_q  <= req_addr_i;
      end else if (wake_ready_i) begin
        wake_valid_q <= 1'b0;
      end
    end
  end

  assign dec_valid_o  = dec_valid_q;
  assign dec_wen_o    = dec_wen_q;
  assign dec_sc_ok_o  = dec_sc_ok_q;
  assign dec_defer_o  = dec_defer_q;
  assign wake_valid_o = wake_valid_q;
  assign wake_id_o    = wake_id_q;
  assign wake_addr_o  = wake_addr_q;

`ifdef MEMPOOL_LRWAIT_STATS_EN
  logic [CntWidth-1:0] stat_defer_q, stat_sc_fail_q, stat_table_full_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_defer_q      <= '0;
      stat_sc_fail_q    <= '0;
      stat_table_full_q <= '0;
    end else if (accept) begin
      if (dec_defer_d && (stat_defer_q != '1))     stat_defer_q      <= stat_defer_q + 1'b1;
      if (sc_fail && (stat_sc_fail_q != '1))       stat_sc_fail_q    <= stat_sc_fail_q + 1'b1;
      if (table_full && (stat_table_full_q != '1)) stat_table_full_q <= stat_table_full_q + 1'b1;
    end
  end

  assign stat_defer_o      = stat_defer_q;
  assign stat_sc_fail_o    = stat_sc_fail_q;
  assign stat_table_full_o = stat_table_full_q;
`endif

endmodule

// File: tb/tb_mempool_lrwait_table.sv
// Directed bench for mempool_lrwait_table: queue-based reference model checked every cycle
// plus literal checks of the hand-computed scenario results.
module tb_mempool_lrwait_table;

  localparam logic [3:0] LR  = 4'hA;
  localparam logic [3:0] SC  = 4'hB;
  localparam logic [3:0] NOP = 4'h0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_addr = '0;
  logic [3:0] req_amo = '0;
  logic       req_lrwait = 1'b0;
  logic       req_wen = 1'b0;
  logic [7:0] req_id = '0;
  logic       dec_valid, dec_wen, dec_sc_ok, dec_defer;
  logic       wake_valid;
  logic       wake_ready = 1'b1;
  logic [7:0] wake_id, wake_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mempool_lrwait_table dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_amo_i    (req_amo),
    .req_lrwait_i (req_lrwait),
    .req_wen_i    (req_wen),
    .req_id_i     (req_id),
    .dec_valid_o  (dec_valid),
    .dec_wen_o    (dec_wen),
    .dec_sc_ok_o  (dec_sc_ok),
    .dec_defer_o  (dec_defer),
    .wake_valid_o (wake_valid),
    .wake_ready_i (wake_ready),
    .wake_id_o    (wake_id),
    .wake_addr_o  (wake_addr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: reservation list, per-address waiter queues, single wake slot.
  bit         m_valid [4];
  logic [7:0] m_addr  [4];
  logic [7:0] m_owner [4];
  int         m_wait  [4][$];
  bit         e_dec_valid = 0, e_wen = 0, e_ok = 0, e_defer = 0;
  bit         e_wake_valid = 0;
  logic [7:0] e_wake_id = '0, e_wake_addr = '0;

  task automatic model_release(input int h);
    if (m_wait[h].size() == 0) begin
      m_valid[h] = 0;
    end else begin
      m_owner[h]   = 8'(m_wait[h].pop_front());
      e_wake_valid = 1;
      e_wake_id    = m_owner[h];
      e_wake_addr  = m_addr[h];
    end
  endtask

  task automatic model_step();
    int  h, f;
    bit  acc;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_valid[i] = 0;
        m_wait[i].delete();
      end
      e_dec_valid = 0; e_wen = 0; e_ok = 0; e_defer = 0; e_wake_valid = 0;
      return;
    end
    acc = req_valid && (!e_wake_valid || wake_ready);
    if (e_wake_valid && wake_ready) e_wake_valid = 0;
    e_dec_valid = acc; e_wen = 0; e_ok = 0; e_defer = 0;
    if (!acc) return;
    h = -1;
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_addr[i] == req_addr) h = i;
    e_wen = req_wen;
    if (req_amo == LR) begin
      if (h >= 0) begin
        if (req_lrwait && m_wait[h].size() < 4) begin
          m_wait[h].push_back(int'(req_id));
          e_defer = 1;
        end
      end else begin
        f = -1;
        for (int i = 3; i >= 0; i--) if (!m_valid[i]) f = i;
        if (f >= 0) begin
          m_valid[f] = 1; m_addr[f] = req_addr; m_owner[f] = req_id;
        end
      end
    end else if (req_amo == SC) begin
      e_ok  = (h >= 0) && (m_owner[h] == req_id);
      e_wen = e_ok;
      if (e_ok) model_release(h);
    end else if (req_wen && h >= 0) begin
      model_release(h);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("req_ready", req_ready, !e_wake_valid || wake_ready);
    chk("dec_valid", dec_valid, e_dec_valid);
    if (e_dec_valid) begin
      chk("dec_wen", dec_wen, e_wen);
      chk("dec_sc_ok", dec_sc_ok, e_ok);
      chk("dec_defer", dec_defer, e_defer);
    end
    chk("wake_valid", wake_valid, e_wake_valid);
    if (e_wake_valid) begin
      chk("wake_id", wake_id, e_wake_id);
      chk("wake_addr", wake_addr, e_wake_addr);
    end
  end

  // One-cycle request; assumes req_ready is high at the accepting edge.
  task automatic send(input logic [3:0] amo, input logic [7:0] addr, input logic [7:0] id,
                      input logic wen, input logic lrw);
    req_valid = 1; req_amo = amo; req_addr = addr; req_id = id; req_wen = wen;
    req_lrwait = lrw;
    @(posedge clk); #2;
    req_valid = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 0;
    chk("reset_wake_valid", wake_valid, 0);
    chk("reset_dec_valid", dec_valid, 0);
    chk("reset_ready", req_ready, 1);

    // LR then SC by the same core succeeds and frees the entry.
    send(LR, 8'h10, 8'd3, 0, 0);
    chk("t1_lr_defer", dec_defer, 0);
    send(SC, 8'h10, 8'd3, 1, 0);
    chk("t1_sc_ok", dec_sc_ok, 1);
    chk("t1_sc_wen", dec_wen, 1);
    send(SC, 8'h10, 8'd3, 1, 0);
    chk("t1_sc_again_ok", dec_sc_ok, 0);

    // Intervening store from another core kills the reservation.
    send(LR, 8'h10, 8'd3, 0, 0);
    send(NOP, 8'h10, 8'd5, 1, 0);
    chk("t2_store_wen", dec_wen, 1);
    send(SC, 8'h10, 8'd3, 1, 0);
    chk("t2_sc_ok", dec_sc_ok, 0);
    chk("t2_sc_wen", dec_wen, 0);

    // LRWait chain hand-off.
    send(LR, 8'h20, 8'd1, 0, 1);
    chk("t3_defer1", dec_defer, 0);
    send(LR, 8'h20, 8'd2, 0, 1);
    chk("t3_defer2", dec_defer, 1);
    send(LR, 8'h20, 8'd3, 0, 1);
    chk("t3_defer3", dec_defer, 1);
    send(SC, 8'h20, 8'd1, 1, 0);
    chk("t3_sc1_ok", dec_sc_ok, 1);
    chk("t3_wake_valid", wake_valid, 1);
    chk("t3_wake_id2", wake_id, 2);
    chk("t3_wake_addr", wake_addr, 8'h20);
    send(SC, 8'h20, 8'd2, 1, 0);
    chk("t3_sc2_ok", dec_sc_ok, 1);
    chk("t3_wake_id3", wake_id, 3);
    send(SC, 8'h20, 8'd3, 1, 0);
    chk("t3_sc3_ok", dec_sc_ok, 1);
    send(NOP, 8'h20, 8'd1, 0, 0);
    chk("read_wen", dec_wen, 0);

    // Wake backpressure gates requests; ready raised accepts in the same cycle.
    send(LR, 8'h30, 8'd1, 0, 0);
    send(LR, 8'h30, 8'd2, 0, 1);
    wake_ready = 0;
    send(SC, 8'h30, 8'd1, 1, 0);
    #1 chk("t5_ready_low", req_ready, 0);
    req_valid = 1; req_amo = LR; req_addr = 8'h40; req_id = 8'd7; req_wen = 0; req_lrwait = 0;
    @(posedge clk); #2;
    chk("t5_not_accepted", dec_valid, 0);
    wake_ready = 1;
    #1 chk("t5_ready_high", req_ready, 1);
    @(posedge clk); #2;
    req_valid = 0;
    chk("t5_accepted", dec_valid, 1);
    chk("t5_wake_done", wake_valid, 0);
    send(SC, 8'h30, 8'd2, 1, 0);
    send(SC, 8'h40, 8'd7, 1, 0);

    // Table full: fifth address gets no reservation.
    for (int i = 0; i < 4; i++) send(LR, 8'(i), 8'(10 + i), 0, 0);
    send(LR, 8'h04, 8'd9, 0, 1);
    chk("t4_full_defer", dec_defer, 0);
    send(SC, 8'h04, 8'd9, 1, 0);
    chk("t4_full_sc_ok", dec_sc_ok, 0);
    chk("t4_full_sc_wen", dec_wen, 0);

    // Reset mid-operation with waiters queued.
    rst = 1;
    @(posedge clk); #2 rst = 0;
    send(LR, 8'h50, 8'd1, 0, 1);
    send(LR, 8'h50, 8'd2, 0, 1);
    send(LR, 8'h50, 8'd3, 0, 1);
    chk("t6_queued", dec_defer, 1);
    rst = 1;
    #1 chk("t6_rst_wake", wake_valid, 0);
    chk("t6_rst_dec", dec_valid, 0);
    @(posedge clk); #2 rst = 0;
    send(LR, 8'h50, 8'd2, 0, 1);
    chk("t6_fresh_defer", dec_defer, 0);
    for (int i = 1; i < 4; i++) send(LR, 8'(8'h60 + i), 8'd4, 0, 0);
    send(LR, 8'h64, 8'd8, 0, 0);
    send(SC, 8'h64, 8'd8, 1, 0);
    chk("t6_full_sc_ok", dec_sc_ok, 0);
    send(SC, 8'h50, 8'd2, 1, 0);
    chk("t6_owner_sc_ok", dec_sc_ok, 1);

    repeat (2) @(posedge clk);
    #1 $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
